latch_bank_write_ctrl: RTL and testbench
========================================

// Module: latch_bank_write_ctrl
// PURPOSE
//  Write scheduler for a bank of DEPTH level-sensitive D latches (d/en/out cells), each W bits wide.
//  Shares the bank between N requesters with round-robin arbitration.
//  For each write it sequences setup, enable pulse and hold so that latch d is stable whenever en is high.
//  Sits between requester logic and the latch bank; it is the only driver of the bank's en and d.
// PARAMETERS
//  N          4  number of requesters (>=2)
//  DEPTH      8  number of latch entries
//  W          8  latch data width
//  AW         3  address width (clog2 DEPTH)
//  EN_CYCLES  1  cycles lat_en is held high per write (>=1)
// PORTS
//  clk     in   1       clock; all state updates on posedge
//  rst     in   1       synchronous reset, active-high
//  req     in   N       per-requester write request; held until matching done
//  addr    in   N*AW    per-requester entry address, requester i at [i*AW +: AW]
//  wdata   in   N*W     per-requester write data, requester i at [i*W +: W]
//  gnt     out  N       one-hot grant to the requester being served
//  done    out  N       one-cycle completion pulse to the served requester
//  err     out  1       one-cycle pulse with done when the address is >= DEPTH
//  busy    out  1       high in any state other than IDLE
//  lat_en  out  DEPTH   one-hot enables to the latch bank
//  lat_d   out  W       shared data bus to all latch d inputs
// BEHAVIOUR
//  - All outputs are registered. On reset: gnt=0, done=0, err=0, busy=0, lat_en=0, lat_d=0, state=IDLE, rr_ptr=0.
//  - FSM states and transitions:
//      IDLE  -> SETUP when |req.
//      SETUP -> EN.
//      EN    -> HOLD after EN_CYCLES cycles in EN.
//      HOLD  -> IDLE.
//  - IDLE, arbitration: winner = first asserted req scanning upward from rr_ptr, wrapping N-1 -> 0.
//    On the edge leaving IDLE, the winner's addr/wdata are captured into lat_d and an address register;
//    gnt[winner] goes high.
//  - SETUP: lat_d stable, lat_en=0, busy=1.
//  - EN: lat_en[addr]=1 for exactly EN_CYCLES cycles; lat_d unchanged.
//    If addr >= DEPTH, lat_en stays 0.
//  - HOLD: lat_en=0, lat_d unchanged, done[winner]=1 and err=(addr>=DEPTH) for this one cycle.
//    rr_ptr <= (winner+1) mod N. gnt drops on the edge leaving HOLD.
//  - Latency: req sampled at edge k -> gnt high from k+1; lat_en high cycles k+2 .. k+1+EN_CYCLES;
//    done at cycle k+2+EN_CYCLES. Back-to-back throughput is one write per EN_CYCLES+3 cycles.
//  - Invariants:
//      lat_en is never high in the same cycle that lat_d changes.
//      At most one lat_en bit is ever high.
//      gnt and done are at most one-hot; done is a subset of gnt.
//  - req/addr/wdata changes after capture are ignored. A req dropped mid-operation still completes, and done still pulses.
//  - Simultaneous requests: exactly one is granted per round. A requester that keeps req high re-enters the rotation only after the others.
//  - Reset mid-operation (any state): at the next edge all outputs take reset values.
//    lat_en drops; the interrupted write carries no completion guarantee.
// STRUCTURE
//  - latch_ctrl_defs.vh: state encodings (IDLE=2'd0, SETUP=2'd1, EN=2'd2, HOLD=2'd3) and the EN-phase counter width.
//  - Sub-module rr_arbiter: combinational round-robin pick. Inputs req[N], ptr; outputs one-hot gnt_nxt and binary idx.
//  - Top: FSM, EN-phase counter, capture registers, address decode to lat_en.
// TESTING
//  Bench carries a behavioural latch-bank model (out follows d while en=1) and checks each entry after every done.
//  1. Single write: req=4'b0001, addr0=5, wdata0=8'hA5, EN_CYCLES=1
//     -> gnt=0001 at k+1, lat_en=8'b0010_0000 only at k+2, done[0] at k+3, entry5=A5.
//  2. All four request at once with distinct addrs/data
//     -> grant order 0,1,2,3; four done pulses 4 cycles apart; all entries correct.
//  3. Fairness: req0 and req2 held high for 4 writes, rr_ptr starting at 0
//     -> order 0,2,0,2; no requester is granted twice in a row while the other waits.
//  4. Out-of-range: addr1=9 with DEPTH=8
//     -> lat_en stays 0 for the whole op; done[1]=1 and err=1 in the same cycle; bank unchanged.
//  5. Stability: wdata/addr toggled every cycle after capture; EN_CYCLES=3
//     -> lat_d constant from SETUP to HOLD; lat_en high exactly 3 cycles; captured value is stored.
//  6. rst=1 during EN
//     -> next cycle lat_en=0, gnt=0, busy=0; after release, a new req0 is served and rr_ptr restarts at 0.

Source files
------------

// File: rtl/latch_bank_write_ctrl_pkg.sv
// Shared definitions for the latch bank write controller.
// Holds the FSM state encodings and a width helper for indices and counters.
package latch_bank_write_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_EN    = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Bits needed to index n items (or count 0..n-1). The result is never
  // less than 1, so a degenerate n still gets a legal vector width.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/latch_bank_write_ctrl_rr_arbiter.sv
// Combinational round-robin pick.
// Ports: req[N] requests, ptr = highest-priority index;
//        gnt_nxt one-hot winner, idx binary winner (both zero when no request).
module latch_bank_write_ctrl_rr_arbiter
  import latch_bank_write_ctrl_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = idx_bits(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_nxt,
  output logic [PW-1:0] idx
);

  logic        found;
  int unsigned pos;

  // Scan upward from ptr, wrapping N-1 -> 0; the first hit wins.
  always_comb begin
    gnt_nxt = '0;
    idx     = '0;
    found   = 1'b0;
    pos     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = (32'(ptr) + i) % N;
      if (!found && req[PW'(pos)]) begin
        found               = 1'b1;
        idx                 = PW'(pos);
        gnt_nxt[PW'(pos)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/latch_bank_write_ctrl.sv
// Write scheduler for a bank of DEPTH level-sensitive latches, shared by N
// requesters under round-robin arbitration. Each write runs
// SETUP (data settles) -> EN (enable pulse) -> HOLD (data held, done),
// so latch d never moves while its enable is high.
// Ports: clk, rst (sync, active-high); req/addr/wdata per requester;
//        gnt/done per requester, err, busy; lat_en one-hot and lat_d to the bank.
module latch_bank_write_ctrl
  import latch_bank_write_ctrl_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned W         = 8,
  parameter int unsigned AW        = 3,
  parameter int unsigned EN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*AW-1:0]  addr,
  input  logic [N*W-1:0]   wdata,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     done,
  output logic             err,
  output logic             busy,
  output logic [DEPTH-1:0] lat_en,
  output logic [W-1:0]     lat_d
);

  localparam int unsigned PW = idx_bits(N);
  localparam int unsigned CW = idx_bits(EN_CYCLES);

  logic [1:0]       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [AW-1:0]    addr_q, addr_nxt;
  logic [PW-1:0]    widx, widx_nxt;
  logic [PW-1:0]    rr_ptr, rr_nxt;
  logic [PW-1:0]    arb_idx;
  logic [N-1:0]     arb_gnt, gnt_nxt, done_nxt;
  logic             err_nxt, busy_nxt, oor;
  logic [DEPTH-1:0] dec, lat_en_nxt;
  logic [W-1:0]     lat_d_nxt;
  logic [W-1:0]     wd_arr [N];
  logic [AW-1:0]    ad_arr [N];

  // Unpack the flat per-requester buses.
  for (genvar g = 0; g < N; g++) begin : g_split
    assign wd_arr[g] = wdata[g*W +: W];
    assign ad_arr[g] = addr[g*AW +: AW];
  end

  // Entry decode of the captured address; an out-of-range address decodes to all zeros.
  for (genvar e = 0; e < DEPTH; e++) begin : g_dec
    assign dec[e] = (32'(addr_q) == 32'(e));
  end
  assign oor = (32'(addr_q) >= DEPTH);

  latch_bank_write_ctrl_rr_arbiter #(
    .N  (N),
    .PW (PW)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt_nxt (arb_gnt),
    .idx     (arb_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    addr_nxt   = addr_q;
    widx_nxt   = widx;
    rr_nxt     = rr_ptr;
    gnt_nxt    = gnt;
    done_nxt   = '0;
    err_nxt    = 1'b0;
    lat_en_nxt = '0;
    lat_d_nxt  = lat_d;
    case (state)
      ST_IDLE: begin
        // Capture happens only here, while lat_en is guaranteed low.
        if (|req) begin
          state_nxt = ST_SETUP;
          gnt_nxt   = arb_gnt;
          widx_nxt  = arb_idx;
          addr_nxt  = ad_arr[arb_idx];
          lat_d_nxt = wd_arr[arb_idx];
        end
      end
      ST_SETUP: begin
        state_nxt  = ST_EN;
        cnt_nxt    = '0;
        lat_en_nxt = dec;
      end
      ST_EN: begin
        if (cnt == CW'(EN_CYCLES - 1)) begin
          state_nxt = ST_HOLD;
          done_nxt  = gnt;
          err_nxt   = oor;
        end else begin
          cnt_nxt    = cnt + CW'(1);
          lat_en_nxt = dec;
        end
      end
      ST_HOLD: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
        rr_nxt    = (widx == PW'(N - 1)) ? '0 : widx + PW'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      addr_q <= '0;
      widx   <= '0;
      rr_ptr <= '0;
      gnt    <= '0;
      done   <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
      lat_en <= '0;
      lat_d  <= '0;
    end else begin
      cnt    <= cnt_nxt;
      addr_q <= addr_nxt;
      widx   <= widx_nxt;
      rr_ptr <= rr_nxt;
      gnt    <= gnt_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      busy   <= busy_nxt;
      lat_en <= lat_en_nxt;
      lat_d  <= lat_d_nxt;
    end
  end

endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// Bench for latch_bank_write_ctrl: two instances (EN_CYCLES 1 and 3, AW=4 so
// out-of-range addresses are reachable), a latch-bank model fed by each DUT,
// and an operation-level reference model of the expected output trace.
module tb_latch_bank_write_ctrl;

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] done;
    logic       err;
    logic       busy;
    logic [7:0] en;
    logic [7:0] d;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req1, req3;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [3:0]  gnt1, done1, gnt3, done3;
  logic        err1, busy1, err3, busy3;
  logic [7:0]  en1, d1, en3, d3;

  latch_bank_write_ctrl #(.N(4), .DEPTH(8), .W(8), .AW(4), .EN_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .addr(addr), .wdata(wdata),
    .gnt(gnt1), .done(done1), .err(err1), .busy(busy1), .lat_en(en1), .lat_d(d1));

  latch_bank_write_ctrl #(.N(4), .DEPTH(8), .W(8), .AW(4), .EN_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .addr(addr), .wdata(wdata),
    .gnt(gnt3), .done(done3), .err(err3), .busy(busy3), .lat_en(en3), .lat_d(d3));

  obs_t       tr [64];
  obs_t       ex [64];
  logic [7:0] bank     [2][8];
  logic [7:0] exp_bank [2][8];
  logic [3:0] m_addr [4];
  logic [7:0] m_data [4];
  int         m_ptr [2];
  logic [7:0] m_lat_d [2];
  int         order_q [$];
  int         obs_order [$];
  int         n_cmp, n_fail;

  // Latch bank: each entry takes d whenever its enable was high in the cycle.
  always @(posedge clk) begin
    for (int e = 0; e < 8; e++) begin
      if (en1[e]) bank[0][e] <= d1;
      if (en3[e]) bank[1][e] <= d3;
    end
  end

  task automatic drive();
    addr  = {m_addr[3], m_addr[2], m_addr[1], m_addr[0]};
    wdata = {m_data[3], m_data[2], m_data[1], m_data[0]};
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ptr[0] = 0; m_ptr[1] = 0;
    m_lat_d[0] = 8'h00; m_lat_d[1] = 8'h00;
  endtask

  // Operation-level reference: each write occupies E+3 cycles starting at
  // its capture edge; cycle c of the trace is the state after edge c-1.
  task automatic model_run(input int sel, input logic [3:0] pend_in,
                           input logic [3:0] sticky, input int e, input int n);
    logic [3:0] pend;
    int s, w, r, a;
    obs_t o;
    pend = pend_in;
    s = 0;
    order_q.delete();
    for (int c = 1; c <= n; c++) begin
      o = '0; o.d = m_lat_d[sel]; ex[c] = o;
    end
    while (s < n && pend != 4'b0) begin
      w = 0;
      for (int j = 3; j >= 0; j--) begin
        r = (m_ptr[sel] + j) % 4;
        if (pend[r[1:0]]) w = r;
      end
      order_q.push_back(w);
      a = int'(m_addr[w]);
      m_lat_d[sel] = m_data[w];
      for (int c = s + 1; c <= n; c++) begin
        ex[c].d = m_data[w];
        if (c <= s + 2 + e) begin ex[c].gnt = 4'(1) << w; ex[c].busy = 1'b1; end
        if (c >= s + 2 && c <= s + 1 + e && a < 8) ex[c].en = 8'(1) << a;
        if (c == s + 2 + e) begin ex[c].done = 4'(1) << w; ex[c].err = (a >= 8); end
      end
      if (a < 8 && s + 2 <= n) exp_bank[sel][a] = m_data[w];
      if (s + 2 + e <= n) begin
        if (!sticky[w[1:0]]) pend[w[1:0]] = 1'b0;
        m_ptr[sel] = (w + 1) % 4;
      end
      s += 3 + e;
    end
  endtask

  // Step n edges, record the chosen DUT, release requests on their done.
  task automatic run(input int sel, input logic [3:0] sticky, input bit toggle, input int n);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (sel == 0) begin
        tr[c] = {gnt1, done1, err1, busy1, en1, d1};
        req1  = req1 & ~(done1 & ~sticky);
      end else begin
        tr[c] = {gnt3, done3, err3, busy3, en3, d3};
        req3  = req3 & ~(done3 & ~sticky);
      end
      if (toggle) begin addr = 16'($urandom); wdata = $urandom; end
    end
  endtask

  task automatic extract_order(input int n);
    obs_order.delete();
    for (int c = 1; c <= n; c++)
      if (tr[c].gnt != 4'b0 && (c == 1 || tr[c-1].gnt == 4'b0))
        for (int j = 0; j < 4; j++) if (tr[c].gnt[j]) obs_order.push_back(j);
  endtask

  task automatic test_reset();
    rst = 1'b1; req1 = '0; req3 = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (gnt1 !== 4'b0)  begin n_fail++; $display("FAIL reset gnt got %h want 0", gnt1); end
    n_cmp++; if (done1 !== 4'b0) begin n_fail++; $display("FAIL reset done got %h want 0", done1); end
    n_cmp++; if (err1 !== 1'b0)  begin n_fail++; $display("FAIL reset err got %b want 0", err1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", busy1); end
    n_cmp++; if (en1 !== 8'b0)   begin n_fail++; $display("FAIL reset lat_en got %h want 0", en1); end
    n_cmp++; if (d1 !== 8'b0)    begin n_fail++; $display("FAIL reset lat_d got %h want 0", d1); end
    n_cmp++; if ({gnt3, done3, err3, busy3, en3, d3} !== 26'b0) begin
      n_fail++; $display("FAIL reset dut3 got %h want 0", {gnt3, done3, err3, busy3, en3, d3});
    end
    rst = 1'b0;
    m_ptr[0] = 0; m_ptr[1] = 0; m_lat_d[0] = 8'h00; m_lat_d[1] = 8'h00;
  endtask

  task automatic test_single();
    m_addr[0] = 4'd5; m_data[0] = 8'hA5; drive();
    req1 = 4'b0001;
    model_run(0, 4'b0001, 4'b0, 1, 5);
    run(0, 4'b0, 1'b0, 5);
    for (int c = 1; c <= 5; c++) begin
      n_cmp++; if (tr[c] !== ex[c]) begin n_fail++; $display("FAIL single cycle %0d got %h want %h", c, tr[c], ex[c]); end
    end
    n_cmp++; if (bank[0][5] !== 8'hA5) begin n_fail++; $display("FAIL single entry5 got %h want a5", bank[0][5]); end
  endtask

  task automatic test_all_four();
    int perm [8];
    int t, j, prev;
    apply_reset();
    for (int i = 0; i < 8; i++) perm[i] = i;
    for (int i = 7; i > 0; i--) begin
      j = int'($urandom_range(i, 0)); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 4; i++) begin m_addr[i] = 4'(perm[i]); m_data[i] = 8'($urandom); end
    drive();
    req1 = 4'b1111;
    model_run(0, 4'b1111, 4'b0, 1, 18);
    run(0, 4'b0, 1'b0, 18);
    for (int c = 1; c <= 18; c++) begin
      n_cmp++; if (tr[c] !== ex[c]) begin n_fail++; $display("FAIL all_four cycle %0d got %h want %h", c, tr[c], ex[c]); end
    end
    extract_order(18);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= obs_order.size() || obs_order[i] != i) begin
        n_fail++; $display("FAIL all_four grant %0d got %0d want %0d", i, (i < obs_order.size()) ? obs_order[i] : -1, i);
      end
    end
    prev = -1;
    for (int c = 1; c <= 18; c++) if (tr[c].done != 4'b0) begin
      if (prev >= 0) begin
        n_cmp++; if (c - prev != 4) begin n_fail++; $display("FAIL all_four done spacing got %0d want 4", c - prev); end
      end
      prev = c;
    end
    for (int e = 0; e < 8; e++) begin
      n_cmp++; if (bank[0][e] !== exp_bank[0][e]) begin n_fail++; $display("FAIL all_four entry%0d got %h want %h", e, bank[0][e], exp_bank[0][e]); end
    end
  endtask

  task automatic test_fairness();
    m_addr[0] = 4'd1; m_data[0] = 8'h3E; m_addr[2] = 4'd6; m_data[2] = 8'hC1; drive();
    req1 = 4'b0101;
    model_run(0, 4'b0101, 4'b0101, 1, 16);
    run(0, 4'b0101, 1'b0, 16);
    req1 = 4'b0;
    for (int c = 1; c <= 16; c++) begin
      n_cmp++; if (tr[c] !== ex[c]) begin n_fail++; $display("FAIL fairness cycle %0d got %h want %h", c, tr[c], ex[c]); end
    end
    extract_order(16);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= obs_order.size() || obs_order[i] != ((i % 2 == 0) ? 0 : 2)) begin
        n_fail++; $display("FAIL fairness grant %0d got %0d want %0d", i, (i < obs_order.size()) ? obs_order[i] : -1, (i % 2 == 0) ? 0 : 2);
      end
    end
    run(0, 4'b0, 1'b0, 2);
  endtask

  task automatic test_out_of_range();
    m_addr[1] = 4'd9; m_data[1] = 8'h77; drive();
    req1 = 4'b0010;
    model_run(0, 4'b0010, 4'b0, 1, 5);
    run(0, 4'b0, 1'b0, 5);
    for (int c = 1; c <= 5; c++) begin
      n_cmp++; if (tr[c] !== ex[c]) begin n_fail++; $display("FAIL oor cycle %0d got %h want %h", c, tr[c], ex[c]); end
    end
    n_cmp++; if (tr[3].done !== 4'b0010 || tr[3].err !== 1'b1) begin
      n_fail++; $display("FAIL oor done/err got %b/%b want 0010/1", tr[3].done, tr[3].err);
    end
    for (int e = 0; e < 8; e++) begin
      n_cmp++; if (bank[0][e] !== exp_bank[0][e]) begin n_fail++; $display("FAIL oor entry%0d got %h want %h", e, bank[0][e], exp_bank[0][e]); end
    end
  endtask

  task automatic test_stability();
    int en_cnt;
    m_addr[0] = 4'd2; m_data[0] = 8'h3C; drive();
    req3 = 4'b0001;
    model_run(1, 4'b0001, 4'b0, 3, 8);
    run(1, 4'b0, 1'b1, 8);
    for (int c = 1; c <= 8; c++) begin
      n_cmp++; if (tr[c] !== ex[c]) begin n_fail++; $display("FAIL stability cycle %0d got %h want %h", c, tr[c], ex[c]); end
    end
    en_cnt = 0;
    for (int c = 1; c <= 8; c++) if (tr[c].en != 8'b0) en_cnt++;
    n_cmp++; if (en_cnt != 3) begin n_fail++; $display("FAIL stability en_cycles got %0d want 3", en_cnt); end
    n_cmp++; if (bank[1][2] !== 8'h3C) begin n_fail++; $display("FAIL stability entry2 got %h want 3c", bank[1][2]); end
  endtask

  task automatic test_random();
    logic [3:0] mask;
    int n;
    for (int rnd = 0; rnd < 6; rnd++) begin
      mask = 4'($urandom_range(15, 1));
      for (int i = 0; i < 4; i++) begin m_addr[i] = 4'($urandom_range(9, 0)); m_data[i] = 8'($urandom); end
      drive();
      req1 = mask;
      n = 4 * $countones(mask) + 2;
      model_run(0, mask, 4'b0, 1, n);
      run(0, 4'b0, 1'b0, n);
      for (int c = 1; c <= n; c++) begin
        n_cmp++; if (tr[c] !== ex[c]) begin n_fail++; $display("FAIL random r%0d cycle %0d got %h want %h", rnd, c, tr[c], ex[c]); end
      end
      for (int e = 0; e < 8; e++) begin
        n_cmp++; if (bank[0][e] !== exp_bank[0][e]) begin n_fail++; $display("FAIL random r%0d entry%0d got %h want %h", rnd, e, bank[0][e], exp_bank[0][e]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    m_addr[0] = 4'd4; m_data[0] = 8'h11; m_addr[2] = 4'd6; m_data[2] = 8'h66; drive();
    req1 = 4'b0001;
    model_run(0, 4'b0001, 4'b0, 1, 2);
    run(0, 4'b0, 1'b0, 2);
    for (int c = 1; c <= 2; c++) begin
      n_cmp++; if (tr[c] !== ex[c]) begin n_fail++; $display("FAIL reset_mid pre cycle %0d got %h want %h", c, tr[c], ex[c]); end
    end
    rst = 1'b1;
    run(0, 4'b0, 1'b0, 1);
    n_cmp++; if (tr[1] !== 26'b0) begin n_fail++; $display("FAIL reset_mid outputs got %h want 0", tr[1]); end
    rst = 1'b0;
    m_ptr[0] = 0; m_ptr[1] = 0; m_lat_d[0] = 8'h00; m_lat_d[1] = 8'h00;
    req1 = 4'b0101;
    model_run(0, 4'b0101, 4'b0, 1, 10);
    run(0, 4'b0, 1'b0, 10);
    for (int c = 1; c <= 10; c++) begin
      n_cmp++; if (tr[c] !== ex[c]) begin n_fail++; $display("FAIL reset_mid post cycle %0d got %h want %h", c, tr[c], ex[c]); end
    end
    extract_order(10);
    n_cmp++; if (obs_order.size() < 1 || obs_order[0] != 0) begin
      n_fail++; $display("FAIL reset_mid first grant got %0d want 0", (obs_order.size() > 0) ? obs_order[0] : -1);
    end
    for (int e = 0; e < 8; e++) begin
      n_cmp++; if (bank[0][e] !== exp_bank[0][e]) begin n_fail++; $display("FAIL reset_mid entry%0d got %h want %h", e, bank[0][e], exp_bank[0][e]); end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    for (int s = 0; s < 2; s++)
      for (int e = 0; e < 8; e++) begin bank[s][e] = 8'h00; exp_bank[s][e] = 8'h00; end
    for (int i = 0; i < 4; i++) begin m_addr[i] = 4'd0; m_data[i] = 8'h00; end
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_out_of_range();
    test_stability();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
